// File: rtl/md4_pkg.sv
// md4_pkg: shared MD4 constants, padder FSM state and block-format modes
package md4_pkg;
   localparam int MD4_BLOCK_BYTES = 64;
   localparam int MD4_LEN_OFS = 56;
   localparam logic [7:0] MD4_PAD_BYTE = 8'h80;
   localparam logic [31:0] MD4_IV_A = 32'h67452301;
   localparam logic [31:0] MD4_IV_B = 32'hefcdab89;
   localparam logic [31:0] MD4_IV_C = 32'h98badcfe;
   localparam logic [31:0] MD4_IV_D = 32'h10325476;
   localparam logic [31:0] MD4_K2 = 32'h5A827999;
   localparam logic [31:0] MD4_K3 = 32'h6ED9EBA1;
   typedef enum logic {FILL, EMIT} md4_pad_state_t;
   typedef enum logic [1:0] {FMT_FIT, FMT_MARK, FMT_TAIL} md4_fmt_mode_t;
endpackage

// File: rtl/md4_msg_padder_if.sv
// md4_msg_padder_if: byte-stream input and 512-bit block output handshakes
// master = host/consumer side, slave = padder side
interface md4_msg_padder_if;
   logic in_valid;
   logic in_ready;
   logic [7:0] in_data;
   logic in_last;
   logic blk_valid;
   logic blk_ready;
   logic [511:0] blk_data;
   logic blk_last;
   modport master (output in_valid, in_data, in_last, blk_ready,
                   input in_ready, blk_valid, blk_data, blk_last);
   modport slave (input in_valid, in_data, in_last, blk_ready,
                  output in_ready, blk_valid, blk_data, blk_last);
endinterface

// File: rtl/md4_pad_fmt.sv
// md4_pad_fmt: combinational MD4 block formatter
// buf_in: partially filled block, p: marker position (64 = none), len: bit length,
// mode: FIT (marker+len) / MARK (marker only) / TAIL (optional marker at byte 0 + len), blk: result
module md4_pad_fmt
   import md4_pkg::*;
(
   input logic [511:0] buf_in,
   input logic [6:0] p,
   input logic [63:0] len,
   input md4_fmt_mode_t mode,
   input logic mark,
   output logic [511:0] blk
);
   for (genvar b = 0; b < MD4_BLOCK_BYTES; b++) begin : g_byte
      localparam logic [6:0] POS = 7'(b);
      logic [7:0] len_b;
      assign len_b = len[8*(b%8) +: 8];
      assign blk[8*b +: 8] = (b >= MD4_LEN_OFS && mode != FMT_MARK) ? len_b :
                             (mode == FMT_TAIL) ? ((b == 0 && mark) ? MD4_PAD_BYTE : 8'h00) :
                             (POS < p) ? buf_in[8*b +: 8] :
                             (POS == p) ? MD4_PAD_BYTE : 8'h00;
   end
endmodule

// File: rtl/md4_msg_padder.sv
// md4_msg_padder: MD4 message padder, byte stream in, 512-bit x blocks out
// clk/rst: clock and sync active-high reset; bus: byte input and block output handshakes
module md4_msg_padder
   import md4_pkg::*;
#(
   parameter int CNT_W = 61
) (
   input logic clk,
   input logic rst,
   md4_msg_padder_if.slave bus
);
   md4_pad_state_t state, state_nx;
   logic [511:0] blk_buf, buf_nx, buf_w, fmt_blk;
   logic [5:0] idx, idx_nx;
   logic [6:0] p;
   logic [CNT_W-1:0] cnt, cnt_nx, len_cnt;
   logic [63:0] len;
   logic tail_pend, pend_nx, tail_mark, mark_nx, last_r, last_nx, hs_in, hs_blk;
   md4_fmt_mode_t mode;
   assign bus.in_ready = state == FILL && !rst;
   assign bus.blk_valid = state == EMIT;
   assign bus.blk_data = blk_buf;
   assign bus.blk_last = last_r;
   assign hs_in = bus.in_valid & bus.in_ready;
   assign hs_blk = bus.blk_valid & bus.blk_ready;
   assign p = 7'(idx) + 7'd1;
   // the final byte's own count is included in the length of a fitting block
   assign len_cnt = state == EMIT ? cnt : cnt + CNT_W'(1);
   assign len = 64'({len_cnt, 3'b000});
   assign mode = state == EMIT ? FMT_TAIL : (p <= 7'(MD4_LEN_OFS - 1)) ? FMT_FIT : FMT_MARK;
   always_comb begin
      buf_w = blk_buf;
      buf_w[{idx, 3'b000} +: 8] = bus.in_data;
   end
   md4_pad_fmt u_fmt (
      .buf_in(buf_w),
      .p(p),
      .len(len),
      .mode(mode),
      .mark(tail_mark),
      .blk(fmt_blk)
   );
   always_comb begin
      state_nx = state;
      buf_nx = blk_buf;
      idx_nx = idx;
      cnt_nx = cnt;
      pend_nx = tail_pend;
      mark_nx = tail_mark;
      last_nx = last_r;
      if (hs_in) begin
         buf_nx = bus.in_last ? fmt_blk : buf_w;
         idx_nx = idx + 6'd1;
         cnt_nx = cnt + CNT_W'(1);
         state_nx = (bus.in_last || idx == 6'd63) ? EMIT : FILL;
         last_nx = bus.in_last && mode == FMT_FIT;
         // MARK with p = 64 leaves the full block untouched; the marker moves to the tail
         pend_nx = bus.in_last && mode == FMT_MARK;
         mark_nx = bus.in_last && p[6];
      end
      if (hs_blk) begin
         buf_nx = tail_pend ? fmt_blk : '0;
         idx_nx = tail_pend ? idx : 6'd0;
         state_nx = tail_pend ? EMIT : FILL;
         last_nx = tail_pend;
         pend_nx = 1'b0;
         mark_nx = 1'b0;
         cnt_nx = last_r ? '0 : cnt;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         blk_buf <= '0;
         idx <= '0;
         cnt <= '0;
         tail_pend <= 1'b0;
         tail_mark <= 1'b0;
         last_r <= 1'b0;
      end else begin
         state <= state_nx;
         blk_buf <= buf_nx;
         idx <= idx_nx;
         cnt <= cnt_nx;
         tail_pend <= pend_nx;
         tail_mark <= mark_nx;
         last_r <= last_nx;
      end
   end
endmodule

// File: tb/tb_md4_msg_padder.sv
// tb_md4_msg_padder: random/directed stimulus against a byte-level MD4 padding model
module tb_md4_msg_padder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared = 0;
   int mismatched = 0;
   logic [7:0] msg[$];
   logic [511:0] exp_blk[$];
   logic exp_last[$];
   logic [511:0] last_blk;
   logic last_flag;

   md4_msg_padder_if bus();
   md4_msg_padder #(.CNT_W(61)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // textbook padding: msg, 0x80, zeros to 56 mod 64, 64-bit LE bit length
   task automatic model();
      logic [7:0] pad[$];
      logic [63:0] len;
      logic [511:0] b;
      int nb;
      pad = msg;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      len = 64'(msg.size()) * 64'd8;
      for (int k = 0; k < 8; k++) pad.push_back(len[8*k +: 8]);
      nb = pad.size() / 64;
      for (int n = 0; n < nb; n++) begin
         for (int i = 0; i < 64; i++) b[8*i +: 8] = pad[64*n + i];
         exp_blk.push_back(b);
         exp_last.push_back(n == nb - 1);
      end
   endtask

   task automatic set_msg(input int n, input int val);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(val < 0 ? 8'($urandom) : 8'(val));
      model();
   endtask

   task automatic drive(input int gap, input int stall, input int hold);
      int i = 0;
      int cyc = 0;
      logic [511:0] held = '0;
      logic held_v = 1'b0;
      while ((i < msg.size() || exp_blk.size() > 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         bus.in_valid = (i < msg.size()) && ($urandom_range(99) >= gap);
         bus.in_data = bus.in_valid ? msg[i] : 8'($urandom);
         bus.in_last = bus.in_valid ? (i == msg.size() - 1) : 1'($urandom);
         if (bus.blk_valid) begin
            chk("excl_in_ready", bus.in_ready, 0);
            chk("blk_expected", exp_blk.size() > 0, 1);
         end
         if (bus.blk_valid && hold > 0) begin
            bus.blk_ready = 1'b0;
            if (held_v) chk("hold_data", bus.blk_data, held);
            else begin
               held = bus.blk_data;
               held_v = 1'b1;
            end
            hold--;
         end else begin
            held_v = 1'b0;
            bus.blk_ready = $urandom_range(99) >= stall;
         end
         if (bus.in_valid && bus.in_ready) i++;
         if (bus.blk_valid && bus.blk_ready && exp_blk.size() > 0) begin
            chk("blk_data", bus.blk_data, exp_blk[0]);
            chk("blk_last", bus.blk_last, exp_last[0]);
            last_blk = bus.blk_data;
            last_flag = bus.blk_last;
            void'(exp_blk.pop_front());
            void'(exp_last.pop_front());
         end
      end
      if (cyc >= 5000) begin
         compared++;
         mismatched++;
         $error("FAIL drive_timeout: observed %0d blocks pending expected 0", exp_blk.size());
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.in_last = 1'b0;
      bus.blk_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_blk_valid", bus.blk_valid, 0);
      chk("rst_blk_data", bus.blk_data, 0);
      chk("rst_blk_last", bus.blk_last, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      msg = '{8'h61, 8'h62, 8'h63};
      model();
      drive(0, 0, 0);
      chk("abc_w0", last_blk[31:0], 32'h80636261);
      chk("abc_mid", last_blk[447:32], 0);
      chk("abc_w14", last_blk[479:448], 32'h00000018);
      chk("abc_w15", last_blk[511:480], 0);
      chk("abc_last", last_flag, 1);
      set_msg(55, 0);
      drive(30, 30, 0);
      chk("z55_b55", last_blk[447:440], 8'h80);
      chk("z55_w14", last_blk[479:448], 32'h000001B8);
      set_msg(56, 8'hFF);
      drive(20, 20, 0);
      chk("ff56_w14", last_blk[479:448], 32'h000001C0);
      chk("ff56_w0", last_blk[31:0], 0);
      set_msg(64, -1);
      drive(0, 0, 0);
      chk("r64_w0", last_blk[31:0], 32'h00000080);
      chk("r64_w14", last_blk[479:448], 32'h00000200);
      set_msg(10, -1);
      drive(0, 0, 5);
      msg = '{8'h61};
      model();
      drive(0, 0, 0);
      chk("a_w0", last_blk[31:0], 32'h00008061);
      chk("a_w14", last_blk[479:448], 32'h00000008);
      for (int t = 0; t < 8; t++) begin
         set_msg(int'($urandom_range(1, 150)), -1);
         drive(40, 40, int'($urandom_range(0, 3)));
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = 8'($urandom);
         bus.in_last = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_blk_valid", bus.blk_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_blk_valid", bus.blk_valid, 0);
      chk("after_rst_in_ready", bus.in_ready, 1);
      chk("after_rst_blk_data", bus.blk_data, 0);
      msg = '{8'h61};
      model();
      drive(0, 0, 0);
      chk("rst_a_w0", last_blk[31:0], 32'h00008061);
      chk("rst_a_w14", last_blk[479:448], 32'h00000008);
      chk("rst_a_last", last_flag, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
